// File: rtl/rf_write_queue.sv
// Regfile write-port merger: pipeline writeback has priority, long-latency results
// wait in a small FIFO, and a pending-address scoreboard flags queued destinations.
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_addr,
  input  logic [31:0]   lu_data,
  output logic          we3,
  output logic [4:0]    wa3,
  output logic [31:0]   wd3,
  input  logic [4:0]    qa1,
  input  logic [4:0]    qa2,
  output logic          q_pend1,
  output logic          q_pend2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_we3;
  logic [4:0]       r_wa3;
  logic [31:0]      r_wd3;

  logic             w_wb;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  // lu_ready looks only at the registered count, so a full FIFO refuses even when popping.
  assign lu_ready = (r_count != L_FULL);
  assign w_wb     = wb_valid && (wb_addr != 5'd0);
  assign w_push   = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign w_pop    = !w_wb && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_we3    <= 1'b0;
      r_wa3    <= 5'd0;
      r_wd3    <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      if (w_wb) begin
        r_we3 <= 1'b1;
        r_wa3 <= wb_addr;
        r_wd3 <= wb_data;
      end else if (w_pop) begin
        r_we3 <= 1'b1;
        r_wa3 <= r_addr[r_rd_ptr];
        r_wd3 <= r_data[r_rd_ptr];
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_addr[r_wr_ptr] <= lu_addr;
      r_data[r_wr_ptr] <= lu_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
    logic [AW-1:0] w_off;
    assign w_off      = AW'(gi) - r_rd_ptr;
    assign w_hit1[gi] = ({1'b0, w_off} < r_count) && (r_addr[gi] == qa1);
    assign w_hit2[gi] = ({1'b0, w_off} < r_count) && (r_addr[gi] == qa2);
  end

  assign q_pend1 = (qa1 != 5'd0) && ((|w_hit1) || (r_we3 && (r_wa3 == qa1)));
  assign q_pend2 = (qa2 != 5'd0) && ((|w_hit2) || (r_we3 && (r_wa3 == qa2)));

  assign we3   = r_we3;
  assign wa3   = r_wa3;
  assign wd3   = r_wd3;
  assign count = r_count;

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a reference FIFO model predicts each regfile
// write into a scoreboard queue that is popped as the output stage updates.
module tb_rf_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  qa1;
  logic [4:0]  qa2;
  logic        q_pend1;
  logic        q_pend2;
  logic [AW:0] count;

  rf_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .qa1(qa1), .qa2(qa2), .q_pend1(q_pend1), .q_pend2(q_pend2),
    .count(count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] m_fifo[$];
  logic [36:0] exp_q[$];
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  logic [AW:0] exp_cnt;
  bit          m_acc;

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (exp_we && exp_wa == a) return 1'b1;
    foreach (m_fifo[i]) if (m_fifo[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock: predict this edge's write into exp_q, then pop it once the DUT updates.
  task automatic tick();
    int sz;
    sz = m_fifo.size();
    m_acc = 1'b0;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
    end else begin
      if (wb_valid && wb_addr != 5'd0) exp_q.push_back({wb_addr, wb_data});
      else if (sz != 0)                exp_q.push_back(m_fifo.pop_front());
      if (lu_valid && sz < DEPTH) begin
        m_acc = 1'b1;
        if (lu_addr != 5'd0) m_fifo.push_back({lu_addr, lu_data});
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      {exp_wa, exp_wd} = exp_q.pop_front();
      exp_we = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    exp_cnt = (AW+1)'(m_fifo.size());
    if (we3) $display("write wa3=%0d wd3=%h count=%0d", wa3, wd3, count);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    qa1 = 5'd5; qa2 = 5'd6;
    tick(); tick();
    n_checks++;
    if (count !== 3'd0 || we3 !== 1'b0 || lu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state count=%0d we3=%0b lu_ready=%0b want 0/0/1", count, we3, lu_ready);
    end
    n_checks++;
    if (wa3 !== 5'd0 || wd3 !== 32'd0 || q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs wa3=%0d wd3=%h pend=%0b%0b want 0/0/00", wa3, wd3, q_pend1, q_pend2);
    end
    rst = 1'b0; idle_inputs();
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (count !== 3'd0 || we3 !== 1'b0) begin
        n_fail++; $display("FAIL reset_nostore count=%0d we3=%0b want 0/0", count, we3);
      end
    end
  endtask

  task automatic test_pipeline();
    idle_inputs();
    qa1 = 5'd3; qa2 = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    tick();
    n_checks++;
    if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'h11 || q_pend1 !== 1'b1) begin
      n_fail++; $display("FAIL pipe_write we3=%0b wa3=%0d wd3=%h pend1=%0b want 1/3/11/1", we3, wa3, wd3, q_pend1);
    end
    wb_addr = 5'd0; wb_data = 32'h22;
    tick();
    n_checks++;
    if (we3 !== 1'b0 || wa3 !== 5'd3 || wd3 !== 32'h11 || q_pend1 !== 1'b0) begin
      n_fail++; $display("FAIL pipe_addr0 we3=%0b wa3=%0d wd3=%h pend1=%0b want 0/3/11/0", we3, wa3, wd3, q_pend1);
    end
  endtask

  task automatic test_priority();
    logic [4:0] want_a [3];
    want_a[0] = 5'd7; want_a[1] = 5'd8; want_a[2] = 5'd0;
    qa1 = 5'd7; qa2 = 5'd8;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c < 5) begin wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h900 + c; end
      if (c == 0) begin lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hA; end
      if (c == 1) begin lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'hB; end
      tick();
      n_checks++;
      if (we3 !== exp_we || (exp_we && (wa3 !== exp_wa || wd3 !== exp_wd))) begin
        n_fail++; $display("FAIL prio_write c=%0d got %0b/%0d/%h want %0b/%0d/%h", c, we3, wa3, wd3, exp_we, exp_wa, exp_wd);
      end
      n_checks++;
      if (count !== exp_cnt || q_pend1 !== m_pend(qa1) || q_pend2 !== m_pend(qa2)) begin
        n_fail++; $display("FAIL prio_state c=%0d count=%0d pend=%0b%0b want %0d/%0b%0b", c, count, q_pend1, q_pend2, exp_cnt, m_pend(qa1), m_pend(qa2));
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (wa3 !== 5'd9 || count !== 3'd2) begin
          n_fail++; $display("FAIL prio_hold c=%0d wa3=%0d count=%0d want 9/2", c, wa3, count);
        end
      end
      if (c >= 5) begin
        n_checks++;
        if ((c < 7 && (we3 !== 1'b1 || wa3 !== want_a[c-5])) || (c == 7 && we3 !== 1'b0)) begin
          n_fail++; $display("FAIL prio_order c=%0d we3=%0b wa3=%0d want addr %0d", c, we3, wa3, want_a[c-5]);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    int k;
    int budget;
    idle_inputs();
    qa1 = 5'd2; qa2 = 5'd6;
    for (int c = 0; c < 5; c++) begin
      wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h2000 + c;
      lu_valid = 1'b1; lu_addr = 5'(c + 1); lu_data = $urandom;
      tick();
      n_checks++;
      if (count !== exp_cnt || lu_ready !== (exp_cnt != DEPTH) || we3 !== 1'b1 || wa3 !== 5'd20) begin
        n_fail++; $display("FAIL fill c=%0d count=%0d lu_ready=%0b we3=%0b wa3=%0d want %0d/%0b/1/20", c, count, lu_ready, we3, wa3, exp_cnt, exp_cnt != DEPTH);
      end
      if (c == 4) begin
        n_checks++;
        if (m_acc || count !== 3'd4 || lu_ready !== 1'b0) begin
          n_fail++; $display("FAIL full_reject count=%0d lu_ready=%0b want 4/0", count, lu_ready);
        end
      end
    end
    k = 0;
    budget = 0;
    wb_valid = 1'b0;
    while ((k < 4 || exp_cnt != 0) && budget < 20) begin
      lu_valid = (k < 4);
      lu_addr  = 5'(k + 5);
      if (m_acc || budget == 0) lu_data = $urandom;
      tick();
      if (m_acc) k++;
      budget++;
      n_checks++;
      if (we3 !== exp_we || (exp_we && (wa3 !== exp_wa || wd3 !== exp_wd))) begin
        n_fail++; $display("FAIL wrap_write got %0b/%0d/%h want %0b/%0d/%h", we3, wa3, wd3, exp_we, exp_wa, exp_wd);
      end
      n_checks++;
      if (count !== exp_cnt || lu_ready !== (exp_cnt != DEPTH) || q_pend1 !== m_pend(qa1) || q_pend2 !== m_pend(qa2)) begin
        n_fail++; $display("FAIL wrap_state count=%0d lu_ready=%0b pend=%0b%0b want %0d/%0b/%0b%0b", count, lu_ready, q_pend1, q_pend2, exp_cnt, exp_cnt != DEPTH, m_pend(qa1), m_pend(qa2));
      end
    end
    n_checks++;
    if (budget != 8) begin
      n_fail++; $display("FAIL wrap_cycles got=%0d want=8", budget);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    qa1 = 5'd12; qa2 = 5'd0;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c < 2) begin wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; end
      if (c == 0) begin lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC; end
      if (c == 4) begin lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hDEAD; end
      tick();
      n_checks++;
      if (q_pend1 !== (c <= 2) || q_pend2 !== 1'b0) begin
        n_fail++; $display("FAIL sb_pend c=%0d pend1=%0b pend2=%0b want %0b/0", c, q_pend1, q_pend2, c <= 2);
      end
      n_checks++;
      if (we3 !== exp_we || (exp_we && (wa3 !== exp_wa || wd3 !== exp_wd)) || count !== exp_cnt) begin
        n_fail++; $display("FAIL sb_write c=%0d got %0b/%0d/%h cnt %0d want %0b/%0d/%h cnt %0d", c, we3, wa3, wd3, count, exp_we, exp_wa, exp_wd, exp_cnt);
      end
      if (c == 2) begin
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd12 || wd3 !== 32'hC) begin
          n_fail++; $display("FAIL sb_pop we3=%0b wa3=%0d wd3=%h want 1/12/c", we3, wa3, wd3);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (we3 !== 1'b0 || count !== 3'd0) begin
          n_fail++; $display("FAIL sb_addr0 c=%0d we3=%0b count=%0d want 0/0", c, we3, count);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    qa1 = 5'd13; qa2 = 5'd15;
    for (int c = 0; c < 3; c++) begin
      wb_valid = 1'b1; wb_addr = 5'd21; wb_data = 32'h2100 + c;
      lu_valid = 1'b1; lu_addr = 5'(13 + c); lu_data = $urandom;
      tick();
    end
    n_checks++;
    if (count !== 3'd3 || we3 !== 1'b1 || q_pend1 !== 1'b1 || q_pend2 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre count=%0d we3=%0b pend=%0b%0b want 3/1/11", count, we3, q_pend1, q_pend2);
    end
    rst = 1'b1; idle_inputs();
    tick();
    n_checks++;
    if (count !== 3'd0 || we3 !== 1'b0 || q_pend1 !== 1'b0 || q_pend2 !== 1'b0 || lu_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst count=%0d we3=%0b pend=%0b%0b lu_ready=%0b want 0/0/00/1", count, we3, q_pend1, q_pend2, lu_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (we3 !== 1'b0 || count !== 3'd0) begin
        n_fail++; $display("FAIL midrst_after c=%0d we3=%0b count=%0d want 0/0", c, we3, count);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_addr  = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      lu_valid = ($urandom_range(0, 1) == 1) && (c < 50);
      lu_addr  = 5'($urandom_range(0, 31));
      lu_data  = $urandom;
      qa1      = 5'($urandom_range(0, 31));
      qa2      = (m_fifo.size() != 0) ? m_fifo[0][36:32] : 5'($urandom_range(0, 31));
      tick();
      n_checks++;
      if (we3 !== exp_we || (exp_we && (wa3 !== exp_wa || wd3 !== exp_wd))) begin
        n_fail++; $display("FAIL b2b_write c=%0d got %0b/%0d/%h want %0b/%0d/%h", c, we3, wa3, wd3, exp_we, exp_wa, exp_wd);
      end
      n_checks++;
      if (count !== exp_cnt || lu_ready !== (exp_cnt != DEPTH) || q_pend1 !== m_pend(qa1) || q_pend2 !== m_pend(qa2)) begin
        n_fail++; $display("FAIL b2b_state c=%0d count=%0d lu_ready=%0b pend=%0b%0b want %0d/%0b/%0b%0b", c, count, lu_ready, q_pend1, q_pend2, exp_cnt, exp_cnt != DEPTH, m_pend(qa1), m_pend(qa2));
      end
    end
    idle_inputs();
  endtask

  initial begin
    exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0; exp_cnt = '0; m_acc = 1'b0;
    rst = 1'b1; qa1 = 5'd0; qa2 = 5'd0;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_priority();
    test_full_wrap();
    test_scoreboard();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
# rf_write_queue

Write-side front end for the register file. It merges two result sources into the single regfile write port (we3/wa3/wd3): the in-order pipeline writeback and a long-latency unit (divider or load-miss path) that returns results out of band. Long-latency results wait in a small FIFO, and a pending-register scoreboard lets the hazard unit stall readers of registers whose writes are still queued. The block sits between the writeback stage and the regfile; its outputs drive the regfile port directly.

## Interface
- DEPTH, 4, number of long-latency result entries; must be a power of two and at least 2.
- AW, 2, log2(DEPTH).
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wb_valid  in  1  pipeline writeback request this cycle; cannot be back-pressured.
- wb_addr  in  5  pipeline destination register.
- wb_data  in  32  pipeline result.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  queue can accept a long-latency result.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency result.
- we3  out  1  regfile write enable; registered.
- wa3  out  5  regfile write address; registered.
- wd3  out  32  regfile write data; registered.
- qa1, qa2  in  5 each  hazard query addresses, normally decode rs and rt.
- q_pend1, q_pend2  out  1 each  the queried register has an outstanding write; combinational.
- count  out  AW+1  FIFO occupancy, range 0..DEPTH.

## Operation
- The FIFO uses circular read and write pointers of AW bits and a count of AW+1 bits. Pointers wrap from DEPTH-1 to 0.
- Push condition: lu_valid && lu_ready && lu_addr!=0.
  - A result for address 0 completes its handshake but is discarded and not stored.
- lu_ready = (count != DEPTH). It depends only on the registered count. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Output stage selection, evaluated each posedge:
  - If wb_valid && wb_addr!=0: load {we3=1, wa3=wb_addr, wd3=wb_data}. The pipeline always has priority.
  - Else if count!=0: pop the FIFO head into the output stage with we3=1.
  - Else: we3=0. wa3 and wd3 hold their previous values.
- A pipeline write to address 0 is dropped and does not block a pop in that cycle.
- A simultaneous push and pop leaves count unchanged; both pointers advance.
- Scoreboard:
  - q_pendN=1 when qaN!=0 and qaN matches the address of any valid FIFO entry, or matches wa3 while we3=1.
  - Valid entries are the count entries starting at the read pointer.
- Ordering: the block does not reorder writes or detect WAW conflicts. The hazard unit must stall any instruction whose destination has q_pend set. The pipeline is also responsible for avoiding starvation: stalling produces writeback bubbles, and the FIFO drains during those bubbles.
- Reset:
  - we3=0, wa3=0, wd3=0.
  - count=0, both pointers 0, lu_ready=1, q_pend1=q_pend2=0.
  - Any lu handshake or wb request presented during rst is ignored.
  - A reset asserted mid-operation discards all queued entries.

## Timing
- The output stage is loaded at posedge N. The regfile samples we3/wa3/wd3 on the following negedge, still within cycle N. A value written at negedge N is readable by decode from cycle N+1.
- Pipeline writeback latency is 1 cycle, from wb_valid to we3.
- Long-latency latency is at least 2 cycles from handshake to we3, because a pushed entry can be popped no earlier than the next posedge. It grows by 1 for every intervening wb_valid cycle.
- q_pend rises in the cycle after the push posedge. It falls in the cycle after the output stage stops holding that address.

## Test plan
- Reset behaviour: assert rst for 2 cycles while lu_valid=1 and lu_addr=5 -> count=0, we3=0, lu_ready=1; no entry is stored.
- Pipeline-only path: wb_valid with addr 3 and data 0x11 -> next cycle we3=1, wa3=3, wd3=0x11. Then wb_valid with addr 0 -> we3=0.
- Priority under contention:
  - Push lu entries (7, 0xA) and (8, 0xB).
  - Hold wb_valid for 3 cycles with addr 9 -> we3 shows addr 9 three times while count stays 2.
  - Drop wb_valid -> addr 7 then addr 8 are written on consecutive cycles, in FIFO order.
- Full and wrap-around:
  - Push 4 entries with wb_valid held high -> count=4, lu_ready=0; a fifth lu_valid is not accepted.
  - Release wb_valid and push 4 more entries over 8 cycles -> all 8 are written in order with the pointers wrapping.
  - Check count on every cycle against a reference model.
- Scoreboard:
  - Push an entry for addr 12 -> q_pend1=1 for qa1=12 from the next cycle until the cycle after we3 shows wa3=12.
  - qa1=0 -> q_pend1=0 at all times.
  - Push an entry for lu_addr=0 -> count is unchanged and no write occurs.
- Mid-operation reset: assert rst with count=3 and we3=1 -> next cycle count=0, we3=0, q_pend1=q_pend2=0, and no queued entry is ever written.
